mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle control FSM that drives the alu block: sequences IF/ID/EXE/MEM/WB, issues ALUOp and operand
//  selects, consumes the ALU Zero flag for branches, and handshakes with a single-port instr/data memory.
//  Sits between the IR register (op/funct) and the datapath muxes/enables. ALUOp codes come from ctrl_encode_def.v.
// PARAMETERS
//  WAIT_MAX  16  max cycles waiting for mem_rdy in IF/MEM before mem_err; 0 = wait forever
//  CNT_W     32  width of perf counters (MC_CTRL_PERF_EN only)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous reset, active-high
//  op        in   6   opcode from IR (stable after IF)
//  funct     in   6   funct from IR
//  zero      in   1   ALU Zero flag
//  mem_rdy   in   1   memory access complete this cycle
//  mem_req   out  1   memory access request (held until mem_rdy)
//  mem_we    out  1   memory write (sw)
//  ir_write  out  1   load IR from memory data
//  pc_write  out  1   update PC
//  pc_src    out  2   00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target {PC[31:28],idx,2'b0}
//  alu_op    out  4   ALUOp to alu (`ALU_* codes)
//  alu_srca  out  1   0 PC, 1 rs
//  alu_srcb  out  2   00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ext_sign  out  1   1 sign-extend imm, 0 zero-extend
//  reg_write out  1   register file write enable
//  reg_dst   out  2   00 rt, 01 rd, 10 $31
//  wd_sel    out  2   00 ALUOut, 01 mem data, 10 PC
//  illegal   out  1   1-cycle pulse in ID on unsupported op/funct
//  mem_err   out  1   1-cycle pulse on WAIT_MAX timeout
//  state     out  3   current state (IF=0 ID=1 EXE=2 MEM=3 WB=4)
// BEHAVIOUR
//  - Outputs are Moore decodes of state + op/funct; while rst=1 every output is 0 and state=IF; async rst mid-op
//    aborts immediately (mem_req drops same cycle), resumes at IF after release. Outputs not listed per state are 0.
//  - IF: mem_req=1, srca=0, srcb=01, `ALU_ADD. On mem_rdy: ir_write=1, pc_write=1, pc_src=00, ->ID; else stay.
//  - ID: srca=0, srcb=11, ext_sign=1, `ALU_ADD (branch target to ALUOut). j: pc_write, pc_src=10, ->IF.
//    jal: as j plus reg_write, reg_dst=10, wd_sel=10, ->IF. Unsupported: illegal=1, ->IF. Else ->EXE.
//  - EXE R-type: srca=1, srcb=00; funct add/sub/and/or/slt/sltu/sll/srl/sra/sllv/nor/xor -> matching `ALU_*; ->WB.
//  - EXE addi/slti: srcb=10, ext_sign=1, ADD/SLT; andi/ori: ext_sign=0, AND/OR; lui: `ALU_LUI; all ->WB.
//  - EXE lw/sw: srca=1, srcb=10, ext_sign=1, ADD, ->MEM. beq/bne: srca=1, srcb=00, `ALU_SUB, pc_src=01,
//    pc_write = zero (beq) / ~zero (bne), ->IF.
//  - MEM: mem_req=1, mem_we=(sw). On mem_rdy: sw ->IF, lw ->WB; else stay.
//  - WB: reg_write=1; reg_dst=01 for R-type else 00; wd_sel=01 for lw else 00; ->IF.
//  - Wait counter: clears on entry to IF/MEM; counts each cycle mem_rdy=0; on reaching WAIT_MAX: mem_err=1,
//    no IR/PC/reg update, ->IF. mem_rdy in the same cycle as the limit wins (normal completion).
//  - CPI: R/I-arith 4, lw 5 (+wait), sw 4, branch 3, j/jal 2.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined: extra outputs cyc_cnt[CNT_W] (+1 every non-reset cycle) and instret[CNT_W]
//  (+1 on each transition back to IF except illegal/mem_err exits); both reset to 0, wrap at 2^CNT_W.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset: rst=1 mid-EXE -> all outputs 0, state=0 same cycle; release -> IF, mem_req=1.
//  - R add (op=000000 funct=100000), mem_rdy=1 in IF -> states 0,1,2,4,0; WB reg_write=1 reg_dst=01 alu_op=`ALU_ADD in EXE.
//  - lw (op=100011), mem_rdy low 3 cycles in MEM -> MEM held 4 cycles, then WB wd_sel=01; sw (101011) -> mem_we=1, no WB.
//  - beq (000100) zero=1 -> EXE pc_write=1 pc_src=01; zero=0 -> pc_write=0; bne (000101) inverse.
//  - jal (000011) -> ID pc_write=1 pc_src=10 reg_write=1 reg_dst=10 wd_sel=10, next state IF; op=111111 -> illegal pulse.
//  - WAIT_MAX=16, mem_rdy held 0 in IF -> mem_err pulse after 16 wait cycles, ir_write/pc_write never asserted.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl - multi-cycle control FSM for the alu datapath.
// Sequences IF/ID/EXE/MEM/WB, drives ALUOp and operand selects, resolves
// branches from the ALU Zero flag, and handshakes with a single-port
// instruction/data memory. A wait counter bounds every memory handshake.
//
// Optional feature: define MC_CTRL_PERF_EN to add the cyc_cnt / instret
// performance counters (and the CNT_W parameter). Without it those ports
// and counters do not exist; everything else behaves identically.
module mc_ctrl #(
  parameter int WAIT_MAX = 16
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       ext_sign,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       illegal,
  output logic       mem_err,
  output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret
`endif
);

  // ALUOp codes shared with the alu block.
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_SLLV = 4'd12;
  localparam logic [3:0] ALU_LUI  = 4'd13;

  // Primary opcodes.
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // R-type funct codes.
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // Wait counter only needs to reach WAIT_MAX.
  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_mem_phase;
  logic                w_timeout;
  logic                w_restart;
  logic [3:0]          w_r_alu_op;
  logic                w_r_legal;
  logic                w_op_legal;
  logic                w_is_r;
  logic                w_is_lw;
  logic                w_is_sw;

  assign w_is_r  = (op == OP_R);
  assign w_is_lw = (op == OP_LW);
  assign w_is_sw = (op == OP_SW);

  assign state = r_state;

  // IF and MEM are the only states that wait on the memory handshake.
  assign w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);

  // Timeout fires once the counter has seen WAIT_MAX idle cycles and memory
  // is still not ready; a ready in that same cycle completes normally.
  generate
    if (WAIT_MAX == 0) begin : g_no_timeout
      assign w_timeout = 1'b0;
    end else begin : g_timeout
      assign w_timeout = !rst && w_mem_phase && !mem_rdy &&
                         (r_wait == WAIT_W'(WAIT_MAX));
    end
  endgenerate

  // Any state change (or the IF->IF timeout retry) starts a fresh wait window.
  assign w_restart = (w_next != r_state) || w_timeout;

  // R-type funct decode to ALUOp plus a legality flag for ID.
  always_comb begin
    w_r_alu_op = ALU_NOP;
    w_r_legal  = 1'b1;
    case (funct)
      F_ADD:   w_r_alu_op = ALU_ADD;
      F_SUB:   w_r_alu_op = ALU_SUB;
      F_AND:   w_r_alu_op = ALU_AND;
      F_OR:    w_r_alu_op = ALU_OR;
      F_SLT:   w_r_alu_op = ALU_SLT;
      F_SLTU:  w_r_alu_op = ALU_SLTU;
      F_SLL:   w_r_alu_op = ALU_SLL;
      F_SRL:   w_r_alu_op = ALU_SRL;
      F_SRA:   w_r_alu_op = ALU_SRA;
      F_SLLV:  w_r_alu_op = ALU_SLLV;
      F_NOR:   w_r_alu_op = ALU_NOR;
      F_XOR:   w_r_alu_op = ALU_XOR;
      default: w_r_legal  = 1'b0;
    endcase
  end

  // Opcode legality check used by ID.
  always_comb begin
    w_op_legal = 1'b0;
    case (op)
      OP_R:    w_op_legal = w_r_legal;
      OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI,
      OP_LW, OP_SW:
               w_op_legal = 1'b1;
      default: w_op_legal = 1'b0;
    endcase
  end

  // State register; async reset returns the sequencer to IF immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory wait counter: cleared on entry to a state, counts idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if (w_restart) begin
      r_wait <= '0;
    end else if (w_mem_phase && !mem_rdy) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Next-state and Moore control decode; everything is held at 0 during reset.
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_op    = ALU_NOP;
    alu_srca  = 1'b0;
    alu_srcb  = 2'b00;
    ext_sign  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IF: begin
          // Fetch and compute PC+4 in parallel.
          mem_req  = 1'b1;
          alu_srca = 1'b0;
          alu_srcb = 2'b01;
          alu_op   = ALU_ADD;
          if (mem_rdy) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'b00;
            w_next   = S_ID;
          end else if (w_timeout) begin
            mem_err = 1'b1;
            w_next  = S_IF;
          end
        end
        S_ID: begin
          // Speculatively compute the branch target into ALUOut.
          alu_srca = 1'b0;
          alu_srcb = 2'b11;
          ext_sign = 1'b1;
          alu_op   = ALU_ADD;
          if (op == OP_J) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            w_next   = S_IF;
          end else if (op == OP_JAL) begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            wd_sel    = 2'b10;
            w_next    = S_IF;
          end else if (!w_op_legal) begin
            illegal = 1'b1;
            w_next  = S_IF;
          end else begin
            w_next = S_EXE;
          end
        end
        S_EXE: begin
          case (op)
            OP_R: begin
              alu_srca = 1'b1;
              alu_srcb = 2'b00;
              alu_op   = w_r_alu_op;
              w_next   = S_WB;
            end
            OP_ADDI, OP_SLTI: begin
              alu_srca = 1'b1;
              alu_srcb = 2'b10;
              ext_sign = 1'b1;
              alu_op   = (op == OP_ADDI) ? ALU_ADD : ALU_SLT;
              w_next   = S_WB;
            end
            OP_ANDI, OP_ORI: begin
              alu_srca = 1'b1;
              alu_srcb = 2'b10;
              ext_sign = 1'b0;
              alu_op   = (op == OP_ANDI) ? ALU_AND : ALU_OR;
              w_next   = S_WB;
            end
            OP_LUI: begin
              alu_srca = 1'b1;
              alu_srcb = 2'b10;
              ext_sign = 1'b0;
              alu_op   = ALU_LUI;
              w_next   = S_WB;
            end
            OP_LW, OP_SW: begin
              // Effective address = rs + sign-extended offset.
              alu_srca = 1'b1;
              alu_srcb = 2'b10;
              ext_sign = 1'b1;
              alu_op   = ALU_ADD;
              w_next   = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              // Compare rs/rt; the target was already latched in ID.
              alu_srca = 1'b1;
              alu_srcb = 2'b00;
              alu_op   = ALU_SUB;
              pc_src   = 2'b01;
              pc_write = (op == OP_BEQ) ? zero : ~zero;
              w_next   = S_IF;
            end
            default: w_next = S_IF;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = w_is_sw;
          if (mem_rdy) begin
            w_next = w_is_sw ? S_IF : S_WB;
          end else if (w_timeout) begin
            mem_err = 1'b1;
            w_next  = S_IF;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = w_is_r ? 2'b01 : 2'b00;
          wd_sel    = w_is_lw ? 2'b01 : 2'b00;
          w_next    = S_IF;
        end
        default: w_next = S_IF;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic w_retire;

  // An instruction retires when control returns to IF by a normal path.
  assign w_retire = (w_next == S_IF) && (r_state != S_IF) && !illegal && !mem_err;

  // Free-running cycle counter and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      instret <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (w_retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl - directed self-checking bench for mc_ctrl (WAIT_MAX = 16).
// Inputs change right after the falling edge; outputs are sampled 1 ns later.
module tb_mc_ctrl;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_SLLV = 4'd12;
  localparam logic [3:0] ALU_LUI  = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic       ext_sign, reg_write;
  logic [1:0] reg_dst, wd_sel;
  logic       illegal, mem_err;
  logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instret;
`endif

  int errors = 0;
  int checks = 0;

  wire [23:0] all_outs = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op,
                          alu_srca, alu_srcb, ext_sign, reg_write, reg_dst,
                          wd_sel, illegal, mem_err, state};

  mc_ctrl #(.WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_op(alu_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .ext_sign(ext_sign), .reg_write(reg_write), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .illegal(illegal), .mem_err(mem_err), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  // One IF cycle with memory ready; leaves the FSM heading to ID.
  task automatic fetch(input logic [5:0] f_op, input logic [5:0] f_funct);
    @(negedge clk); op = f_op; funct = f_funct; mem_rdy = 1'b1; zero = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_outs !== 24'd0) begin
      $display("FAIL reset_outputs: got %h expected 000000", all_outs); errors++;
    end
    @(negedge clk); rst = 1'b0; op = OP_R; funct = F_ADD; #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b1 || ir_write !== 1'b0) begin
      $display("FAIL reset_release: state=%0d mem_req=%0b ir_write=%0b expected 0/1/0",
               state, mem_req, ir_write); errors++;
    end
    checks++;
    if (alu_srca !== 1'b0 || alu_srcb !== 2'b01 || alu_op !== ALU_ADD) begin
      $display("FAIL if_alu_setup: srca=%0b srcb=%b alu_op=%0d expected 0/01/%0d",
               alu_srca, alu_srcb, alu_op, ALU_ADD); errors++;
    end
    $display("tb: reset released, state=%0d mem_req=%0b", state, mem_req);
  endtask

  task automatic test_rtype_add();
    fetch(OP_R, F_ADD);
    checks++;
    if (state !== 3'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00) begin
      $display("FAIL add_if: state=%0d ir_write=%0b pc_write=%0b pc_src=%b expected 0/1/1/00",
               state, ir_write, pc_write, pc_src); errors++;
    end
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd1 || alu_srcb !== 2'b11 || ext_sign !== 1'b1 || pc_write !== 1'b0) begin
      $display("FAIL add_id: state=%0d srcb=%b ext_sign=%0b pc_write=%0b expected 1/11/1/0",
               state, alu_srcb, ext_sign, pc_write); errors++;
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd2 || alu_op !== ALU_ADD || alu_srca !== 1'b1 || alu_srcb !== 2'b00) begin
      $display("FAIL add_exe: state=%0d alu_op=%0d srca=%0b srcb=%b expected 2/%0d/1/00",
               state, alu_op, alu_srca, alu_srcb, ALU_ADD); errors++;
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd4 || reg_write !== 1'b1 || reg_dst !== 2'b01 || wd_sel !== 2'b00) begin
      $display("FAIL add_wb: state=%0d reg_write=%0b reg_dst=%b wd_sel=%b expected 4/1/01/00",
               state, reg_write, reg_dst, wd_sel); errors++;
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0) begin
      $display("FAIL add_return: state=%0d expected 0", state); errors++;
    end
    $display("tb: add retired, sequence IF-ID-EXE-WB-IF");
  endtask

  task automatic test_alu_table();
    logic [5:0] fn [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011,
                            6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b100111, 6'b100110};
    logic [3:0] ex [12] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU,
                            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_NOR, ALU_XOR};
    for (int i = 0; i < 12; i++) begin
      fetch(OP_R, fn[i]);
      @(negedge clk); mem_rdy = 1'b0; #1;
      @(negedge clk); #1;
      checks++;
      if (state !== 3'd2 || alu_op !== ex[i]) begin
        $display("FAIL rtype_aluop funct=%b: state=%0d alu_op=%0d expected 2/%0d",
                 fn[i], state, alu_op, ex[i]); errors++;
      end
      @(negedge clk); #1;
      checks++;
      if (state !== 3'd4 || reg_write !== 1'b1) begin
        $display("FAIL rtype_wb funct=%b: state=%0d reg_write=%0b expected 4/1",
                 fn[i], state, reg_write); errors++;
      end
      $display("tb: R funct=%b alu_op=%0d", fn[i], alu_op);
    end
  endtask

  task automatic test_reset_mid_op();
    fetch(OP_R, F_ADD);
    @(negedge clk); mem_rdy = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd2) begin
      $display("FAIL midrst_pre: state=%0d expected 2", state); errors++;
    end
    rst = 1'b1; #1;
    checks++;
    if (all_outs !== 24'd0) begin
      $display("FAIL midrst_outputs: got %h expected 000000", all_outs); errors++;
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b1) begin
      $display("FAIL midrst_release: state=%0d mem_req=%0b expected 0/1", state, mem_req); errors++;
    end
    $display("tb: async reset in EXE aborted instruction");
  endtask

  task automatic test_lw_sw();
    fetch(OP_LW, 6'd0);
    @(negedge clk); mem_rdy = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd2 || alu_srca !== 1'b1 || alu_srcb !== 2'b10 || ext_sign !== 1'b1 || alu_op !== ALU_ADD) begin
      $display("FAIL lw_exe: state=%0d srca=%0b srcb=%b ext=%0b alu_op=%0d expected 2/1/10/1/%0d",
               state, alu_srca, alu_srcb, ext_sign, alu_op, ALU_ADD); errors++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_rdy = 1'b0; #1;
      checks++;
      if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
        $display("FAIL lw_mem_wait%0d: state=%0d mem_req=%0b mem_we=%0b expected 3/1/0",
                 k, state, mem_req, mem_we); errors++;
      end
    end
    @(negedge clk); mem_rdy = 1'b1; #1;
    checks++;
    if (state !== 3'd3 || mem_req !== 1'b1) begin
      $display("FAIL lw_mem_done: state=%0d mem_req=%0b expected 3/1", state, mem_req); errors++;
    end
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd4 || wd_sel !== 2'b01 || reg_dst !== 2'b00 || reg_write !== 1'b1) begin
      $display("FAIL lw_wb: state=%0d wd_sel=%b reg_dst=%b reg_write=%0b expected 4/01/00/1",
               state, wd_sel, reg_dst, reg_write); errors++;
    end
    $display("tb: lw retired after 3 memory wait cycles");
    fetch(OP_SW, 6'd0);
    @(negedge clk); mem_rdy = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); mem_rdy = 1'b1; #1;
    checks++;
    if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      $display("FAIL sw_mem: state=%0d mem_req=%0b mem_we=%0b expected 3/1/1", state, mem_req, mem_we); errors++;
    end
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd0 || reg_write !== 1'b0) begin
      $display("FAIL sw_no_wb: state=%0d reg_write=%0b expected 0/0", state, reg_write); errors++;
    end
    $display("tb: sw retired without WB");
  endtask

  task automatic test_itype();
    logic [5:0] ops [3] = '{OP_ADDI, OP_ORI, OP_LUI};
    logic [3:0] aop [3] = '{ALU_ADD, ALU_OR, ALU_LUI};
    logic       sgn [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      fetch(ops[i], 6'd0);
      @(negedge clk); mem_rdy = 1'b0; #1;
      @(negedge clk); #1;
      checks++;
      if (state !== 3'd2 || alu_srcb !== 2'b10 || alu_op !== aop[i] || ext_sign !== sgn[i]) begin
        $display("FAIL itype_exe op=%b: state=%0d srcb=%b alu_op=%0d ext=%0b expected 2/10/%0d/%0b",
                 ops[i], state, alu_srcb, alu_op, ext_sign, aop[i], sgn[i]); errors++;
      end
      @(negedge clk); #1;
      checks++;
      if (state !== 3'd4 || reg_dst !== 2'b00 || wd_sel !== 2'b00 || reg_write !== 1'b1) begin
        $display("FAIL itype_wb op=%b: state=%0d reg_dst=%b wd_sel=%b reg_write=%0b expected 4/00/00/1",
                 ops[i], state, reg_dst, wd_sel, reg_write); errors++;
      end
      $display("tb: I-type op=%b alu_op=%0d", ops[i], alu_op);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       pw  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      fetch(ops[i], 6'd0);
      @(negedge clk); mem_rdy = 1'b0; #1;
      @(negedge clk); zero = zs[i]; #1;
      checks++;
      if (state !== 3'd2 || pc_write !== pw[i] || pc_src !== 2'b01 || alu_op !== ALU_SUB) begin
        $display("FAIL branch op=%b zero=%0b: state=%0d pc_write=%0b pc_src=%b alu_op=%0d expected 2/%0b/01/%0d",
                 ops[i], zs[i], state, pc_write, pc_src, alu_op, pw[i], ALU_SUB); errors++;
      end
      @(negedge clk); zero = 1'b0; #1;
      checks++;
      if (state !== 3'd0) begin
        $display("FAIL branch_return op=%b: state=%0d expected 0", ops[i], state); errors++;
      end
      $display("tb: branch op=%b zero=%0b pc_write=%0b", ops[i], zs[i], pw[i]);
    end
  endtask

  task automatic test_jumps_illegal();
    fetch(OP_JAL, 6'd0);
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd1 || pc_write !== 1'b1 || pc_src !== 2'b10 || reg_write !== 1'b1 ||
        reg_dst !== 2'b10 || wd_sel !== 2'b10) begin
      $display("FAIL jal_id: state=%0d pw=%0b pc_src=%b rw=%0b rd=%b wd=%b expected 1/1/10/1/10/10",
               state, pc_write, pc_src, reg_write, reg_dst, wd_sel); errors++;
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0) begin
      $display("FAIL jal_return: state=%0d expected 0", state); errors++;
    end
    $display("tb: jal retired in 2 cycles");
    fetch(OP_J, 6'd0);
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd1 || pc_write !== 1'b1 || pc_src !== 2'b10 || reg_write !== 1'b0) begin
      $display("FAIL j_id: state=%0d pw=%0b pc_src=%b rw=%0b expected 1/1/10/0",
               state, pc_write, pc_src, reg_write); errors++;
    end
    $display("tb: j retired in 2 cycles");
    fetch(6'b111111, 6'd0);
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd1 || illegal !== 1'b1 || pc_write !== 1'b0) begin
      $display("FAIL illegal_op: state=%0d illegal=%0b pc_write=%0b expected 1/1/0",
               state, illegal, pc_write); errors++;
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0) begin
      $display("FAIL illegal_pulse: state=%0d illegal=%0b expected 0/0", state, illegal); errors++;
    end
    $display("tb: op=111111 flagged illegal");
    fetch(OP_R, 6'b001000);
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd1 || illegal !== 1'b1) begin
      $display("FAIL illegal_funct: state=%0d illegal=%0b expected 1/1", state, illegal); errors++;
    end
    $display("tb: R funct=001000 flagged illegal");
  endtask

  task automatic test_timeout();
    int bad;
    // Run an add through WB so IF is entered with a cleared wait counter.
    fetch(OP_R, F_ADD);
    @(negedge clk); mem_rdy = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); mem_rdy = 1'b0; #1;
      if (state !== 3'd0 || mem_err !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      $display("FAIL timeout_wait: %0d of 16 wait cycles wrong, expected 0", bad); errors++;
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0 || mem_err !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      $display("FAIL timeout_err: state=%0d mem_err=%0b ir_write=%0b pc_write=%0b expected 0/1/0/0",
               state, mem_err, ir_write, pc_write); errors++;
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0 || mem_err !== 1'b0) begin
      $display("FAIL timeout_pulse: state=%0d mem_err=%0b expected 0/0", state, mem_err); errors++;
    end
    $display("tb: IF timeout after 16 wait cycles");
    // Fresh window: ready arrives exactly at the limit and must win.
    repeat (15) begin
      @(negedge clk); mem_rdy = 1'b0; #1;
    end
    @(negedge clk); mem_rdy = 1'b1; #1;
    checks++;
    if (mem_err !== 1'b0 || ir_write !== 1'b1) begin
      $display("FAIL limit_rdy_wins: mem_err=%0b ir_write=%0b expected 0/1", mem_err, ir_write); errors++;
    end
    @(negedge clk); mem_rdy = 1'b0; #1;
    checks++;
    if (state !== 3'd1) begin
      $display("FAIL limit_rdy_next: state=%0d expected 1", state); errors++;
    end
    $display("tb: mem_rdy at the wait limit completed the fetch");
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_alu_table();
    test_reset_mid_op();
    test_lw_sw();
    test_itype();
    test_branch();
    test_jumps_illegal();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
